// File: rtl/fee_ctrl.sv
// fee_ctrl: parking-meter session controller feeding start/seltime/selmoney to the 7-segment scanner.
// Optional: define FEE_CTRL_RUN_ADD_EN to let key_add extend the time while the countdown runs.
module fee_ctrl #(
  parameter int SEC_DIV    = 1000,
  parameter int STEP       = 1,
  parameter int RATE       = 2,
  parameter int HOLD_TICKS = 3
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       key_start,
  input  logic       key_add,
  input  logic       key_confirm,
  input  logic       key_cancel,
  output logic       start,
  output logic [6:0] seltime,
  output logic [6:0] selmoney,
  output logic       busy,
  output logic       done
);

  // state     | meaning
  // ST_OFF    | display dark, waiting for a start press
  // ST_SELECT | user adds time units, confirm starts the countdown
  // ST_RUN    | counting seltime down once per tick, charge frozen
  // ST_DONE   | session over, charge shown for HOLD_TICKS ticks
  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_SELECT = 2'd1,
    ST_RUN    = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int TW = $clog2(SEC_DIV);
  localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(SEC_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);

  localparam int K_START   = 0;
  localparam int K_ADD     = 1;
  localparam int K_CONFIRM = 2;
  localparam int K_CANCEL  = 3;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [3:0]    w_keys;
  logic [3:0]    r_sync1;
  logic [3:0]    r_sync2;
  logic [3:0]    r_prev;
  logic [3:0]    w_evt;
  logic [6:0]    r_seltime;
  logic [6:0]    r_selmoney;
  logic [6:0]    w_time_nxt;
  logic [6:0]    w_money_nxt;
  logic [6:0]    w_sel_time;
  logic [6:0]    w_sel_money;
  logic [6:0]    w_run_base;
  logic [TW-1:0] r_tick_cnt;
  logic [HW-1:0] r_hold_cnt;
  logic          r_done;
  logic          w_timed;
  logic          w_tick;
  logic          w_hold_done;

  function automatic logic [6:0] sat99(input logic [15:0] v);
    return (v > 16'd99) ? 7'd99 : v[6:0];
  endfunction

  assign w_keys = {key_cancel, key_confirm, key_add, key_start};
  assign w_evt  = r_sync2 & ~r_prev;

  assign w_timed     = (r_state == ST_RUN) || (r_state == ST_DONE);
  assign w_tick      = w_timed && (r_tick_cnt == TICK_LAST);
  assign w_hold_done = w_tick && (r_hold_cnt == HOLD_LAST);

  // Charge is derived from the already-saturated time, so it tracks what the user sees.
  assign w_sel_time  = sat99(16'(r_seltime) + 16'(STEP));
  assign w_sel_money = sat99(16'(w_sel_time) * 16'(RATE));
  assign w_run_base  = w_tick ? (r_seltime - 7'd1) : r_seltime;

`ifdef FEE_CTRL_RUN_ADD_EN
  logic [6:0] w_run_time;
  logic [6:0] w_run_money;
  assign w_run_time  = sat99(16'(w_run_base) + 16'(STEP));
  assign w_run_money = sat99(16'(r_selmoney) + 16'(STEP * RATE));
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_time_nxt  = r_seltime;
    w_money_nxt = r_selmoney;
    case (r_state)
      ST_OFF: begin
        w_time_nxt  = 7'd0;
        w_money_nxt = 7'd0;
        if (w_evt[K_START]) w_state_nxt = ST_SELECT;
      end
      ST_SELECT: begin
        if (w_evt[K_CANCEL]) begin
          w_state_nxt = ST_OFF;
          w_time_nxt  = 7'd0;
          w_money_nxt = 7'd0;
        end else if (w_evt[K_CONFIRM] && (r_seltime != 7'd0)) begin
          w_state_nxt = ST_RUN;
        end else if (w_evt[K_ADD]) begin
          w_time_nxt  = w_sel_time;
          w_money_nxt = w_sel_money;
        end
      end
      ST_RUN: begin
        if (w_evt[K_CANCEL]) begin
          w_state_nxt = ST_OFF;
          w_time_nxt  = 7'd0;
          w_money_nxt = 7'd0;
        end else if (w_tick && (r_seltime <= 7'd1)) begin
          w_state_nxt = ST_DONE;
          w_time_nxt  = 7'd0;
        end else begin
          w_time_nxt = w_run_base;
`ifdef FEE_CTRL_RUN_ADD_EN
          if (w_evt[K_ADD]) begin
            w_time_nxt  = w_run_time;
            w_money_nxt = w_run_money;
          end
`endif
        end
      end
      ST_DONE: begin
        w_time_nxt = 7'd0;
        if (w_evt[K_CANCEL] || w_hold_done) begin
          w_state_nxt = ST_OFF;
          w_money_nxt = 7'd0;
        end else if (w_evt[K_START]) begin
          w_state_nxt = ST_SELECT;
          w_money_nxt = 7'd0;
        end
        // a start press outranks hold expiry on the same edge
        if (!w_evt[K_CANCEL] && w_evt[K_START]) w_state_nxt = ST_SELECT;
      end
      default: begin
        w_state_nxt = ST_OFF;
        w_time_nxt  = 7'd0;
        w_money_nxt = 7'd0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_OFF;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_prev     <= '0;
      r_seltime  <= '0;
      r_selmoney <= '0;
      r_tick_cnt <= '0;
      r_hold_cnt <= '0;
      r_done     <= 1'b0;
    end else begin
      r_sync1    <= w_keys;
      r_sync2    <= r_sync1;
      r_prev     <= r_sync2;
      r_seltime  <= w_time_nxt;
      r_selmoney <= w_money_nxt;
      r_done     <= (w_state_nxt == ST_DONE) && (r_state != ST_DONE);
      if ((w_state_nxt != r_state) || w_tick || !w_timed) begin
        r_tick_cnt <= '0;
      end else begin
        r_tick_cnt <= r_tick_cnt + TW'(1);
      end
      if ((r_state != ST_DONE) || (w_state_nxt != ST_DONE)) begin
        r_hold_cnt <= '0;
      end else if (w_tick) begin
        r_hold_cnt <= r_hold_cnt + HW'(1);
      end
    end
  end

  assign start    = (r_state != ST_OFF);
  assign busy     = (r_state == ST_RUN);
  assign done     = r_done;
  assign seltime  = r_seltime;
  assign selmoney = r_selmoney;

endmodule

// File: tb/tb_fee_ctrl.sv
// tb_fee_ctrl: directed plus randomized key stimulus against a session-level model of fee_ctrl.
// Build with FEE_CTRL_RUN_ADD_EN defined to exercise adding time during the countdown.
module tb_fee_ctrl;

  localparam int SEC_DIV    = 4;
  localparam int STEP       = 1;
  localparam int RATE       = 2;
  localparam int HOLD_TICKS = 3;

  localparam int M_OFF  = 0;
  localparam int M_SEL  = 1;
  localparam int M_RUN  = 2;
  localparam int M_DONE = 3;

  logic       CLK   = 1'b0;
  logic       RST_N = 1'b1;
  logic [3:0] kb    = 4'b0000;   // {cancel, confirm, add, start}
  logic       start;
  logic       busy;
  logic       done;
  logic [6:0] seltime;
  logic [6:0] selmoney;

  fee_ctrl #(
    .SEC_DIV   (SEC_DIV),
    .STEP      (STEP),
    .RATE      (RATE),
    .HOLD_TICKS(HOLD_TICKS)
  ) u_dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .key_start  (kb[0]),
    .key_add    (kb[1]),
    .key_confirm(kb[2]),
    .key_cancel (kb[3]),
    .start      (start),
    .seltime    (seltime),
    .selmoney   (selmoney),
    .busy       (busy),
    .done       (done)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  // session-level reference: mode, shown values, cycles since entering a timed mode
  int       m_mode, m_time, m_money, m_tc, m_held;
  bit       m_done;
  bit [3:0] h1, h2, h3;   // key samples taken 1, 2 and 3 edges ago

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int min99(input int v);
    return (v > 99) ? 99 : v;
  endfunction

  task automatic model_reset();
    m_mode = M_OFF; m_time = 0; m_money = 0; m_tc = 0; m_held = 0; m_done = 1'b0;
    h1 = '0; h2 = '0; h3 = '0;
  endtask

  task automatic model_edge(input bit [3:0] k);
    bit [3:0] ev;
    bit       tick;
    int       old;
    ev   = h2 & ~h3;
    h3   = h2; h2 = h1; h1 = k;
    tick = ((m_mode == M_RUN) || (m_mode == M_DONE)) && (m_tc == SEC_DIV - 1);
    old  = m_mode;
    case (m_mode)
      M_OFF: if (ev[0]) begin m_mode = M_SEL; m_time = 0; m_money = 0; end
      M_SEL: begin
        if (ev[3]) begin m_mode = M_OFF; m_time = 0; m_money = 0; end
        else if (ev[2] && m_time > 0) m_mode = M_RUN;
        else if (ev[1]) begin
          m_time  = min99(m_time + STEP);
          m_money = min99(m_time * RATE);
        end
      end
      M_RUN: begin
        if (ev[3]) begin m_mode = M_OFF; m_time = 0; m_money = 0; end
        else begin
          if (tick) begin
            m_time = m_time - 1;
            if (m_time == 0) m_mode = M_DONE;
          end
`ifdef FEE_CTRL_RUN_ADD_EN
          if (ev[1] && m_mode == M_RUN) begin
            m_time  = min99(m_time + STEP);
            m_money = min99(m_money + STEP * RATE);
          end
`endif
        end
      end
      default: begin
        if (ev[3]) begin m_mode = M_OFF; m_money = 0; end
        else if (ev[0]) begin m_mode = M_SEL; m_money = 0; end
        else if (tick) begin
          m_held++;
          if (m_held == HOLD_TICKS) begin m_mode = M_OFF; m_money = 0; end
        end
      end
    endcase
    if (m_mode != old) begin m_tc = 0; m_held = 0; end
    else if (m_mode == M_RUN || m_mode == M_DONE) m_tc = tick ? 0 : m_tc + 1;
    else m_tc = 0;
    m_done = (m_mode == M_DONE) && (old != M_DONE);
  endtask

  task automatic check_outputs();
    chk("start",    start,    (m_mode != M_OFF));
    chk("seltime",  seltime,  m_time);
    chk("selmoney", selmoney, m_money);
    chk("busy",     busy,     (m_mode == M_RUN));
    chk("done",     done,     m_done);
  endtask

  task automatic cycle();
    @(posedge CLK);
    if (RST_N) model_edge(kb);
    else model_reset();
    @(negedge CLK);
    check_outputs();
  endtask

  task automatic press(input int k);
    kb[k] = 1'b1; cycle();
    kb[k] = 1'b0; cycle();
  endtask

  task automatic settle();
    repeat (3) cycle();
  endtask

  task automatic async_reset();
    #2 RST_N = 1'b0;
    #1;
    model_reset();
    chk("arst_start",    start,    0);
    chk("arst_seltime",  seltime,  0);
    chk("arst_selmoney", selmoney, 0);
    chk("arst_busy",     busy,     0);
    chk("arst_done",     done,     0);
  endtask

  initial begin
    int  nd, di, ri, oi;
    bit  found;
    model_reset();
    #1 RST_N = 1'b0;
    repeat (3) cycle();
    RST_N = 1'b1;
    repeat (20) cycle();

    // select and charge, with key latency and hold-as-one-press
    press(0);
    repeat (5) press(1);
    settle();
    chk("sel5_time", seltime, 5);
    chk("sel5_money", selmoney, 10);
    chk("sel5_start", start, 1);
    kb[1] = 1'b1;
    cycle(); chk("lat_k", seltime, 5);
    cycle(); chk("lat_k1", seltime, 5);
    cycle(); chk("lat_k2", seltime, 6);
    repeat (48) cycle();
    chk("hold_one_press", seltime, 6);
    kb[1] = 1'b0;
    settle();

    // saturation
    press(3); settle();
    press(0);
    repeat (60) press(1);
    settle();
    chk("sat60_time", seltime, 60);
    chk("sat60_money", selmoney, 99);
    repeat (45) press(1);
    settle();
    chk("sat99_time", seltime, 99);
    chk("sat99_money", selmoney, 99);

    // countdown 3 -> 0, done pulse, hold, back to OFF
    press(3); settle();
    press(0);
    repeat (3) press(1);
    press(2);
    nd = 0; di = -1; ri = -1; oi = -1;
    for (int i = 0; i < 80; i++) begin
      cycle();
      if (busy && ri < 0) ri = i;
      if (done) begin nd++; di = i; end
      if (!start && di >= 0) begin oi = i; break; end
    end
    chk("cd_done_pulses", nd, 1);
    chk("cd_run_len", di - ri, 12);
    chk("cd_hold_len", oi - di, 12);

    // confirm with zero time stays in SELECT
    press(0); press(2); settle();
    chk("zero_confirm_busy", busy, 0);
    chk("zero_confirm_start", start, 1);

    // cancel arriving on the same edge as a tick
    press(3); settle();
    press(0);
    repeat (3) press(1);
    press(2);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (m_mode == M_RUN && m_tc == 1) begin found = 1'b1; break; end
    end
    chk("cancel_wait", found, 1);
    kb[3] = 1'b1; cycle();
    kb[3] = 1'b0; cycle();
    chk("cancel_pre_time", seltime, 3);
    cycle();
    chk("cancel_tick_start", start, 0);
    chk("cancel_tick_time", seltime, 0);
    settle();

    // add during RUN, then async reset mid-RUN
    press(0);
    repeat (4) press(1);
    press(2);
    cycle();
    chk("run_entry_busy", busy, 1);
    press(1);
    cycle();
`ifdef FEE_CTRL_RUN_ADD_EN
    chk("run_add_time", seltime, 5);
    chk("run_add_money", selmoney, 10);
`else
    chk("run_add_time", seltime, 4);
    chk("run_add_money", selmoney, 8);
`endif
    async_reset();
    cycle(); cycle();
    RST_N = 1'b1;
    settle();

    // randomized key traffic with occasional async resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 999) < 3) begin
        async_reset();
        cycle();
        RST_N = 1'b1;
      end
      if ($urandom_range(0, 99) < 8)  kb[0] = ~kb[0];
      if ($urandom_range(0, 99) < 30) kb[1] = ~kb[1];
      if ($urandom_range(0, 99) < 6)  kb[2] = ~kb[2];
      if ($urandom_range(0, 99) < 2)  kb[3] = ~kb[3];
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fee_ctrl.md
Name: fee_ctrl

Overview:
- Upstream control stage for the two-pair 7-segment scanner of the parking-fee meter.
- Turns user button presses into the `start` enable and the two 0..99 values the scanner shows: the `seltime` pair and the `selmoney` pair.
- Runs a select/confirm/countdown session and drives `start`, `seltime` and `selmoney` directly into the scanner.

Parameters:
- SEC_DIV, 1000: CLK cycles per countdown tick (≥2).
- STEP, 1: time units added per key_add press.
- RATE, 2: money units charged per time unit.
- HOLD_TICKS, 3: ticks the DONE state is held before returning to OFF.

Ports:
- CLK  in  1  system clock; all state updates on its rising edge.
- RST_N  in  1  asynchronous active-low reset.
- key_start  in  1  raw button, level, asynchronous to CLK.
- key_add  in  1  raw button, level, asynchronous.
- key_confirm  in  1  raw button, level, asynchronous.
- key_cancel  in  1  raw button, level, asynchronous.
- start  out  1  display enable; 1 in every state except OFF.
- seltime  out  7  remaining/selected time, 0..99.
- selmoney  out  7  charge, 0..99.
- busy  out  1  1 in RUN only.
- done  out  1  one-cycle pulse on entry to DONE.

Behaviour:
- Reset (RST_N=0, asynchronous): state=OFF, start=0, seltime=0, selmoney=0, busy=0, done=0. Synchronizers, edge registers and tick counter are also cleared. Reset mid-session aborts immediately; there is no resume.
- Key input path, per key:
  - 2-FF synchronizer, then a previous-value register.
  - event = sync2 & ~prev, giving one event per rising edge of the button.
  - A key first sampled high at edge k takes effect in the registered outputs at edge k+2.
  - Holding a key produces no further events. No debounce inside this block; inputs arrive pre-debounced.
- Event priority within one cycle: cancel > confirm > add > start. Only the highest-priority event that is valid in the current state acts; the others are dropped.
- Tick counter:
  - Counts 0..SEC_DIV-1 in RUN and DONE only. A tick is asserted when the count = SEC_DIV-1, and the counter then wraps to 0.
  - Cleared on entry to RUN and on entry to DONE.
- States:
  - OFF: start=0, seltime=0, selmoney=0.
    - start event → SELECT, with seltime=0, selmoney=0.
  - SELECT: start=1.
    - add event: seltime = min(seltime+STEP, 99); selmoney = min(new seltime*RATE, 99). Compute in ≥14-bit intermediate width, then saturate to 99.
    - confirm event with seltime>0 → RUN. confirm with seltime=0 is ignored.
    - cancel event → OFF, all outputs cleared.
    - start event is ignored.
  - RUN: start=1, busy=1, selmoney frozen.
    - On each tick: seltime decrements by 1. If seltime was 1 → DONE, seltime=0.
    - cancel event → OFF.
    - add, confirm and start events are ignored (see Optional Feature for add).
  - DONE: start=1, seltime=0, selmoney held; done=1 for exactly the entry cycle.
    - After HOLD_TICKS ticks → OFF.
    - start event → SELECT (fresh session: seltime=0, selmoney=0).
    - cancel event → OFF.
- Simultaneous tick and cancel in RUN: cancel wins; no decrement, no done pulse.
- Outputs are registered; seltime and selmoney never exceed 99. The unused encodings of the 2-bit state register recover to OFF on the next edge.

Optional Feature:
- Macro: FEE_CTRL_RUN_ADD_EN.
- Defined:
  - In RUN, an add event sets seltime = min(seltime+STEP, 99) and selmoney = min(selmoney+STEP*RATE, 99).
  - The tick counter is not disturbed.
  - If the add coincides with a tick, the decrement applies first, then the add.
- Undefined: add events in RUN are ignored, with identical outputs in both cases otherwise.

Test Plan:
- Reset then idle: RST_N low for 3 cycles, then high, all keys low → start=0, seltime=0, selmoney=0, busy=0 for 20 cycles.
- Select and charge (RATE=2): start press, then 5 add presses → seltime=5, selmoney=10, start=1. Each update appears 2 edges after the key is first sampled high. Holding add high for 50 cycles counts as one press.
- Saturation: 60 add presses with RATE=2 → seltime=60, selmoney=99. A further 45 presses → seltime=99, selmoney=99.
- Countdown (SEC_DIV=4, HOLD_TICKS=3): seltime=3, confirm → busy=1. Values go 3→2→1→0 at 4-cycle spacing, done pulses for 1 cycle, start stays 1 for 12 cycles, then OFF.
- Zero confirm and cancel priority:
  - confirm with seltime=0 → remains in SELECT.
  - In RUN, cancel on the same cycle as a tick → OFF, no decrement, done never pulses.
- Async reset mid-RUN: RST_N pulled low between edges → all outputs 0 immediately, without waiting for an edge. With FEE_CTRL_RUN_ADD_EN, an add during RUN from seltime=4 gives seltime=5 and selmoney+2.
